score_display_scanner: RTL and testbench
========================================

// Module: score_display_scanner
// PURPOSE
//  Upstream feeder of the single-digit glyph decoder. Accepts a binary score and converts it
//  to BCD with a sequential shift-add-3 FSM. Time-multiplexes the digits onto one glyph-code
//  bus, SingleGraphic, with a one-hot digit select. Leading zeros are blanked. Out-of-range
//  scores show dashes on every digit.
// PARAMETERS
//  NUM_DIGITS  4     number of multiplexed digits; max displayable = 10^NUM_DIGITS-1
//  SCORE_W     14    width of binary score input
//  SCAN_DIV    1000  clk cycles each digit stays selected (>=2)
//  BLANK_CODE  34    glyph code for all-segments-off
//  DASH_CODE   36    glyph code for centre dash
// PORTS
//  clk            in   1           system clock, rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  score_valid    in   1           one-cycle strobe: score is valid
//  score          in   SCORE_W     binary score to display
//  busy           out  1           conversion in progress; strobes are dropped
//  overflow       out  1           latched score exceeded 10^NUM_DIGITS-1
//  SingleGraphic  out  8           glyph code of the currently selected digit
//  digit_sel      out  NUM_DIGITS  one-hot, active-high; bit 0 = rightmost (least significant) digit
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FSM=IDLE; busy=0; overflow=0; display buffer all 0.
//   - prescaler=0; digit index=0; digit_sel=1; SingleGraphic=0.
//  FSM: IDLE -> CONVERT -> COMMIT -> IDLE.
//   - IDLE: score_valid=1 accepts on that edge and latches score.
//     - If score > 10^NUM_DIGITS-1: go to COMMIT with overflow pending.
//     - Else: clear the BCD shift register, load the bit counter, go to CONVERT.
//     - busy=1 from the accepting edge onward.
//   - CONVERT: exactly SCORE_W edges. Each edge adds 3 to every BCD nibble >=5, then shifts
//     the {BCD, bin} register left 1. Then go to COMMIT.
//   - COMMIT: one edge.
//     - Copy BCD to the display buffer, or mark all digits dash.
//     - overflow <= pending flag; busy <= 0; go to IDLE.
//  Latency:
//   - In-range score: buffer updates SCORE_W+1 edges after the accepting edge.
//   - Overflow score: buffer updates 1 edge after the accepting edge.
//  score_valid while busy=1 is ignored. No queueing; the previous display stays until COMMIT.
//  The display buffer changes only on the COMMIT edge. The scan never glitches mid-conversion.
//  Scanner (free-running, independent of FSM):
//   - Prescaler counts 0..SCAN_DIV-1 and wraps.
//   - On wrap the digit index advances by 1, wrapping NUM_DIGITS-1 -> 0.
//  Outputs are registered every edge from the current index and buffer (1-cycle lag):
//   - digit_sel = 1 << index.
//   - SingleGraphic:
//     - DASH_CODE if overflow.
//     - Else BLANK_CODE if index>0 and buffer digits index..NUM_DIGITS-1 are all 0.
//     - Else the BCD value 0..9.
//   - Digit 0 is never blanked (score 0 shows "0").
//  A reset during CONVERT aborts the conversion: outputs return to reset values and the
//  partial result is discarded.
// TESTING (bench uses SCAN_DIV=4, defaults otherwise)
//  1. Reset mid-scan:
//     - Response: digit_sel=0001, SingleGraphic=0, busy=0 while rst_n=0.
//     - After release: digit_sel advances every 4 clk.
//  2. score=1234 strobe:
//     - busy high 15 edges.
//     - Then scan yields 4,3,2,1 for digit_sel 0001,0010,0100,1000, repeating.
//  3. score=7:
//     - Scan yields 7,34,34,34.
//     - Then score=0: yields 0,34,34,34.
//     - Then score=9000: yields 0,0,0,9.
//  4. score=10000 (and 16383):
//     - overflow=1 one edge after accept.
//     - All digits 36.
//     - A following score=5 clears overflow and shows 5,34,34,34.
//  5. score=1234 accepted, score=5678 strobed 3 cycles later:
//     - Second strobe is ignored; display shows 1234.
//  6. score=4321 accepted, rst_n pulsed low during CONVERT:
//     - Buffer stays 0.
//     - Display shows 0,34,34,34; busy=0.

Source files
------------

// File: rtl/score_display_scanner.sv
// Binary score to BCD (shift-add-3) with a time-multiplexed, leading-zero-blanked
// glyph output for a single-digit decoder.
module score_display_scanner #(
   parameter int         NUM_DIGITS = 4,
   parameter int         SCORE_W    = 14,
   parameter int         SCAN_DIV   = 1000,
   parameter logic [7:0] BLANK_CODE = 8'd34,
   parameter logic [7:0] DASH_CODE  = 8'd36
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  score_valid,
   input  logic [SCORE_W-1:0]    score,
   output logic                  busy,
   output logic                  overflow,
   output logic [7:0]            SingleGraphic,
   output logic [NUM_DIGITS-1:0] digit_sel
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(SCORE_W + 1);
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0] MAX_SCORE = pow10(NUM_DIGITS) - 64'd1;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int d = 0; d < NUM_DIGITS; d++)
         if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t             state, nextState;
   logic [SCORE_W-1:0] binReg;
   logic [BCD_W-1:0]   bcdReg;
   logic [BCD_W-1:0]   dispBuf;
   logic [CNT_W-1:0]   bitCnt;
   logic               pendOvf;
   logic               scoreTooBig;
   logic [PRE_W-1:0]   prescaler;
   logic [IDX_W-1:0]   digitIdx;
   logic               upperZero;
   logic [3:0]         curDigit;
   logic [7:0]         glyph;

   assign scoreTooBig = 64'(score) > MAX_SCORE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (score_valid) nextState = scoreTooBig ? COMMIT : CONVERT;
         CONVERT: if (bitCnt == '0) nextState = COMMIT;
         COMMIT:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Out-of-range scores leave the buffer alone; the overflow flag alone drives the dashes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         binReg   <= '0;
         bcdReg   <= '0;
         dispBuf  <= '0;
         bitCnt   <= '0;
         pendOvf  <= 1'b0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (score_valid) begin
               busy    <= 1'b1;
               binReg  <= score;
               bcdReg  <= '0;
               bitCnt  <= CNT_W'(SCORE_W - 1);
               pendOvf <= scoreTooBig;
            end
            CONVERT: begin
               {bcdReg, binReg} <= {add3(bcdReg), binReg} << 1;
               bitCnt           <= bitCnt - CNT_W'(1);
            end
            COMMIT: begin
               if (!pendOvf) dispBuf <= bcdReg;
               overflow <= pendOvf;
               busy     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         digitIdx  <= '0;
      end else if (prescaler == PRE_W'(SCAN_DIV - 1)) begin
         prescaler <= '0;
         digitIdx  <= (digitIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx + IDX_W'(1);
      end else begin
         prescaler <= prescaler + PRE_W'(1);
      end
   end

   // A digit is blank only when it and every more-significant digit are zero.
   always_comb begin
      upperZero = 1'b1;
      curDigit  = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (IDX_W'(d) >= digitIdx && dispBuf[4*d +: 4] != 4'd0) upperZero = 1'b0;
         if (IDX_W'(d) == digitIdx) curDigit = dispBuf[4*d +: 4];
      end
      if (overflow)                          glyph = DASH_CODE;
      else if (digitIdx != '0 && upperZero)  glyph = BLANK_CODE;
      else                                   glyph = {4'd0, curDigit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_sel     <= NUM_DIGITS'(1);
         SingleGraphic <= 8'd0;
      end else begin
         digit_sel     <= NUM_DIGITS'(1) << digitIdx;
         SingleGraphic <= glyph;
      end
   end

endmodule

// File: tb/tb_score_display_scanner.sv
// Directed scoreboard bench for score_display_scanner with a fast scan divider.
module tb_score_display_scanner;

   logic        clk;
   logic        rst_n;
   logic        score_valid;
   logic [13:0] score;
   logic        busy;
   logic        overflow;
   logic [7:0]  SingleGraphic;
   logic [3:0]  digit_sel;

   int checks = 0;
   int errors = 0;
   int expQ[$];
   int busyCnt;

   score_display_scanner #(.SCAN_DIV(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .score_valid(score_valid),
      .score(score),
      .busy(busy),
      .overflow(overflow),
      .SingleGraphic(SingleGraphic),
      .digit_sel(digit_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int value);
      score_valid = 1'b1;
      score       = 14'(value);
      @(negedge clk);
      score_valid = 1'b0;
   endtask

   // Counts falling edges seen with busy high; ends one edge after COMMIT updates the glyph.
   task automatic waitIdle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic pushDisplay(input int d0, input int d1, input int d2, input int d3);
      expQ.push_back(d0);
      expQ.push_back(d1);
      expQ.push_back(d2);
      expQ.push_back(d3);
   endtask

   task automatic checkScan(input int rounds);
      int n;
      int exp;
      for (int r = 0; r < rounds; r++) begin
         for (int i = 0; i < 4; i++) begin
            n = 0;
            while (digit_sel !== 4'(1 << i) && n < 40) begin
               n++;
               @(negedge clk);
            end
            checkOutput($sformatf("scan_sel_r%0d_d%0d", r, i), 32'(digit_sel), 32'(1 << i));
            exp = expQ.pop_front();
            checkOutput($sformatf("scan_glyph_r%0d_d%0d", r, i), 32'(SingleGraphic), 32'(exp));
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      score_valid = 1'b0;
      score       = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_sel", 32'(digit_sel), 32'd1);
      checkOutput("rst_glyph", 32'(SingleGraphic), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ovf", 32'(overflow), 32'd0);

      // Reset in the middle of a scan, then verify the 4-clock cadence
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_sel", 32'(digit_sel), 32'd1);
      checkOutput("midrst_glyph", 32'(SingleGraphic), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("cadence_0", 32'(digit_sel), 32'd1);
      @(negedge clk);
      checkOutput("cadence_1", 32'(digit_sel), 32'd2);
      repeat (4) @(negedge clk);
      checkOutput("cadence_2", 32'(digit_sel), 32'd4);
      repeat (4) @(negedge clk);
      checkOutput("cadence_3", 32'(digit_sel), 32'd8);
      repeat (4) @(negedge clk);
      checkOutput("cadence_wrap", 32'(digit_sel), 32'd1);

      $display("[TB] score 1234");
      applyStimulus(1234);
      pushDisplay(4, 3, 2, 1);
      pushDisplay(4, 3, 2, 1);
      waitIdle(busyCnt);
      checkOutput("busy_len_1234", 32'(busyCnt), 32'd15);
      checkOutput("ovf_1234", 32'(overflow), 32'd0);
      checkScan(2);

      $display("[TB] leading-zero blanking");
      applyStimulus(7);
      pushDisplay(7, 34, 34, 34);
      waitIdle(busyCnt);
      checkScan(1);
      applyStimulus(0);
      pushDisplay(0, 34, 34, 34);
      waitIdle(busyCnt);
      checkScan(1);
      applyStimulus(9000);
      pushDisplay(0, 0, 0, 9);
      waitIdle(busyCnt);
      checkScan(1);
      applyStimulus(9999);
      pushDisplay(9, 9, 9, 9);
      waitIdle(busyCnt);
      checkOutput("ovf_9999", 32'(overflow), 32'd0);
      checkScan(1);

      $display("[TB] overflow");
      applyStimulus(10000);
      pushDisplay(36, 36, 36, 36);
      checkOutput("ovf_busy_10000", 32'(busy), 32'd1);
      waitIdle(busyCnt);
      checkOutput("busy_len_10000", 32'(busyCnt), 32'd1);
      checkOutput("ovf_10000", 32'(overflow), 32'd1);
      checkScan(1);
      applyStimulus(16383);
      pushDisplay(36, 36, 36, 36);
      waitIdle(busyCnt);
      checkOutput("busy_len_16383", 32'(busyCnt), 32'd1);
      checkOutput("ovf_16383", 32'(overflow), 32'd1);
      checkScan(1);
      applyStimulus(5);
      pushDisplay(5, 34, 34, 34);
      waitIdle(busyCnt);
      checkOutput("ovf_clear_5", 32'(overflow), 32'd0);
      checkScan(1);

      $display("[TB] strobe while busy");
      applyStimulus(1234);
      pushDisplay(4, 3, 2, 1);
      repeat (2) @(negedge clk);
      applyStimulus(5678);
      waitIdle(busyCnt);
      checkScan(1);
      repeat (3) @(negedge clk);
      checkOutput("no_requeue_busy", 32'(busy), 32'd0);

      $display("[TB] reset during conversion");
      applyStimulus(4321);
      repeat (5) @(negedge clk);
      checkOutput("convert_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_sel", 32'(digit_sel), 32'd1);
      checkOutput("abort_glyph", 32'(SingleGraphic), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pushDisplay(0, 34, 34, 34);
      checkScan(1);
      checkOutput("abort_busy_after", 32'(busy), 32'd0);
      checkOutput("abort_ovf_after", 32'(overflow), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
